// File: rtl/event_filter_seq_if.sv
// Handshake bundle of the event filter sequencer:
// input byte strobe, filter issue/verdict, output byte stream.
interface event_filter_seq_if;
  logic [7:0] in_byte;
  logic       in_valid;
  logic [7:0] f_x;
  logic [7:0] f_y;
  logic       f_p;
  logic [7:0] f_t;
  logic       f_valid;
  logic       f_ready;
  logic       r_valid;
  logic       r_pass;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;

  modport master (
    input  in_byte,
    input  in_valid,
    input  f_ready,
    input  r_valid,
    input  r_pass,
    input  out_ready,
    output f_x,
    output f_y,
    output f_p,
    output f_t,
    output f_valid,
    output out_byte,
    output out_valid
  );

  modport slave (
    output in_byte,
    output in_valid,
    output f_ready,
    output r_valid,
    output r_pass,
    output out_ready,
    input  f_x,
    input  f_y,
    input  f_p,
    input  f_t,
    input  f_valid,
    input  out_byte,
    input  out_valid
  );
endinterface

// File: rtl/event_filter_seq.sv
// Event filter sequencer: assembles 4-byte AER packets, issues them
// to the filter, and re-serializes the ones the filter keeps.
module event_filter_seq #(
  parameter int TIMEOUT = 255,
  parameter int DROP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  event_filter_seq_if.master bus,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              err_timeout,
  output logic              err_overrun
);

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);
  localparam logic [DROP_W-1:0] DROP_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_ISSUE,
    S_WAIT,
    S_EMIT
  } state_e;

  state_e state_q, state_d;

  logic [1:0]  idx_q, idx_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic        p_q, p_d;
  logic [7:0]  t_q, t_d;
  logic [1:0]  oidx_q, oidx_d;
  logic [7:0]  obyte_q, obyte_d;
  logic        ovalid_q, ovalid_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic        eto_q, eto_d;
  logic        eov_q, eov_d;

  logic [1:0]  oidx_nx;
  logic [7:0]  nx_byte;
  logic        in_busy;

  assign oidx_nx = oidx_q + 2'd1;
  assign in_busy = (state_q == S_ISSUE)
                || (state_q == S_WAIT)
                || (state_q == S_EMIT);

  // Flags byte goes out with only the polarity bit populated.
  always_comb begin
    nx_byte = '0;
    unique case (oidx_nx)
      2'd0: nx_byte = x_q;
      2'd1: nx_byte = y_q;
      2'd2: nx_byte = {p_q, 7'b0};
      2'd3: nx_byte = t_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    x_d      = x_q;
    y_d      = y_q;
    p_d      = p_q;
    t_d      = t_q;
    oidx_d   = oidx_q;
    obyte_d  = obyte_q;
    ovalid_d = ovalid_q;
    drop_d   = drop_q;
    eto_d    = eto_q;
    eov_d    = eov_q;
    if (ena) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            x_d     = bus.in_byte;
            idx_d   = 2'd1;
            timer_d = '0;
            state_d = S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (bus.in_valid) begin
            unique case (idx_q)
              2'd1:    y_d = bus.in_byte;
              2'd2:    p_d = bus.in_byte[7];
              2'd3:    t_d = bus.in_byte;
              default: x_d = bus.in_byte;
            endcase
            timer_d = '0;
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_d = S_ISSUE;
            end
          end else if (timer_q + 16'd1 == TO_LIM) begin
            timer_d = '0;
            idx_d   = '0;
            eto_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        S_ISSUE: begin
          if (bus.f_ready) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.r_valid && bus.r_pass) begin
            oidx_d   = '0;
            obyte_d  = x_q;
            ovalid_d = 1'b1;
            state_d  = S_EMIT;
          end else if (bus.r_valid) begin
            if (drop_q != '1) begin
              drop_d = drop_q + DROP_ONE;
            end
            state_d = S_IDLE;
          end
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            if (oidx_q == 2'd3) begin
              oidx_d   = '0;
              obyte_d  = '0;
              ovalid_d = 1'b0;
              state_d  = S_IDLE;
            end else begin
              oidx_d  = oidx_nx;
              obyte_d = nx_byte;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
      // A byte landing on the return-to-idle cycle is silently lost.
      if (bus.in_valid && in_busy && state_d != S_IDLE) begin
        eov_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      timer_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      p_q      <= 1'b0;
      t_q      <= '0;
      oidx_q   <= '0;
      obyte_q  <= '0;
      ovalid_q <= 1'b0;
      drop_q   <= '0;
      eto_q    <= 1'b0;
      eov_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      x_q      <= x_d;
      y_q      <= y_d;
      p_q      <= p_d;
      t_q      <= t_d;
      oidx_q   <= oidx_d;
      obyte_q  <= obyte_d;
      ovalid_q <= ovalid_d;
      drop_q   <= drop_d;
      eto_q    <= eto_d;
      eov_q    <= eov_d;
    end
  end

  assign bus.f_x       = x_q;
  assign bus.f_y       = y_q;
  assign bus.f_p       = p_q;
  assign bus.f_t       = t_q;
  assign bus.f_valid   = (state_q == S_ISSUE);
  assign bus.out_byte  = obyte_q;
  assign bus.out_valid = ovalid_q;

  assign busy        = (state_q != S_IDLE);
  assign drop_cnt    = drop_q;
  assign err_timeout = eto_q;
  assign err_overrun = eov_q;

endmodule

// File: tb/tb_event_filter_seq.sv
// Randomized bench for event_filter_seq against a packet-level
// model: expected output byte queue, drop count and sticky flags.
module tb_event_filter_seq;
  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic       busy;
  logic [7:0] drop_cnt;
  logic       err_timeout;
  logic       err_overrun;

  event_filter_seq_if bus ();

  event_filter_seq #(
    .TIMEOUT(TO),
    .DROP_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .bus        (bus),
    .busy       (busy),
    .drop_cnt   (drop_cnt),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] got[$];
  logic [7:0] expq[$];
  int drop_exp = 0;
  bit to_exp = 0;
  bit ov_exp = 0;
  int ordy_mode = 0;
  bit hold = 0;
  logic [7:0] prev = '0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      bus.r_valid = ($urandom % 4 == 0);
      bus.r_pass  = 1'($urandom % 2);
      cyc();
    end
    bus.r_valid  = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    @(negedge clk);
    chk("fv_low", bus.f_valid, 0);
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] pkt, input int maxgap);
    int g;
    for (int i = 0; i < 4; i++) begin
      g = 0;
      if (i > 0) begin
        g = ($urandom % 4 == 0) ? maxgap : $urandom_range(0, maxgap);
      end
      send_byte(pkt[31-8*i -: 8], g);
    end
  endtask

  task automatic issue_verdict(input logic [31:0] pkt, input int fdly,
                               input int vlat, input bit pass,
                               input bit ovr);
    bus.f_ready = 1'b0;
    for (int k = 0; k <= fdly; k++) begin
      if (k == fdly) bus.f_ready = 1'b1;
      @(negedge clk);
      chk("fv", bus.f_valid, 1);
      chk("fx", bus.f_x, pkt[31:24]);
      chk("fy", bus.f_y, pkt[23:16]);
      chk("fp", bus.f_p, pkt[15]);
      chk("ft", bus.f_t, pkt[7:0]);
      cyc();
    end
    bus.f_ready = 1'b0;
    @(negedge clk);
    chk("fv_end", bus.f_valid, 0);
    for (int k = 0; k < vlat; k++) begin
      cyc();
      bus.in_valid = (ovr && k == 0);
      bus.in_byte  = 8'($urandom);
    end
    cyc();
    bus.in_valid = 1'b0;
    bus.r_valid  = 1'b1;
    bus.r_pass   = pass;
    cyc();
    bus.r_valid = 1'b0;
    if (ovr) ov_exp = 1;
    if (pass) begin
      expq.push_back(pkt[31:24]);
      expq.push_back(pkt[23:16]);
      expq.push_back({pkt[15], 7'b0});
      expq.push_back(pkt[7:0]);
    end else begin
      drop_exp = (drop_exp >= 255) ? 255 : drop_exp + 1;
    end
  endtask

  task automatic finish_pkt(input bit pass);
    if (pass) begin
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (!busy) break;
      end
      chk("busy_end", busy, 0);
      cyc();
      chk("nout", got.size(), expq.size());
      while (expq.size() > 0 && got.size() > 0)
        chk("obyte", got.pop_front(), expq.pop_front());
      got.delete();
      expq.delete();
    end else begin
      @(negedge clk);
      chk("nout_rej", got.size(), 0);
      chk("busy_rej", busy, 0);
      cyc();
      got.delete();
    end
    chk("drop", drop_cnt, drop_exp);
    chk("eto", err_timeout, to_exp);
    chk("eov", err_overrun, ov_exp);
  endtask

  task automatic do_pkt(input logic [31:0] pkt, input int maxgap,
                        input int fdly, input int vlat, input bit pass,
                        input bit ovr);
    send_pkt(pkt, maxgap);
    issue_verdict(pkt, fdly, vlat, pass, ovr);
    finish_pkt(pass);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_fv"}, bus.f_valid, 0);
    chk({tag, "_fx"}, {bus.f_x, bus.f_y, bus.f_t}, 0);
    chk({tag, "_fp"}, bus.f_p, 0);
    chk({tag, "_ov"}, bus.out_valid, 0);
    chk({tag, "_ob"}, bus.out_byte, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_drop"}, drop_cnt, 0);
    chk({tag, "_err"}, {err_timeout, err_overrun}, 0);
  endtask

  // Sink: output-side ready pattern
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ordy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom % 2);
        default: bus.out_ready = ~bus.out_ready;
      endcase
    end
  end

  // Monitor: collect transferred bytes, check hold under backpressure
  initial begin
    forever begin
      @(negedge clk);
      if (hold && bus.out_valid) chk("hold", bus.out_byte, prev);
      if (rst_n && bus.out_valid && bus.out_ready)
        got.push_back(bus.out_byte);
      hold = bus.out_valid && !bus.out_ready;
      prev = bus.out_byte;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.in_byte  = '0;
    bus.in_valid = 1'b0;
    bus.f_ready  = 1'b0;
    bus.r_valid  = 1'b0;
    bus.r_pass   = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    @(negedge clk);
    chk_zero("rst");
    cyc();
    rst_n = 1'b1;
    ena   = 1'b1;
    cyc();

    // Pass path, back-to-back bytes, ready sinks
    do_pkt(32'h12348056, 0, 0, 2, 1, 0);

    // Enable low freezes the timeout counter mid-packet
    send_byte(8'hA1, 0);
    send_byte(8'hB2, 1);
    ena = 1'b0;
    repeat (3 * TO) cyc();
    @(negedge clk);
    chk("frz_busy", busy, 1);
    chk("frz_eto", err_timeout, 0);
    cyc();
    ena = 1'b1;
    send_byte(8'h7F, 0);
    send_byte(8'hC3, 0);
    issue_verdict(32'hA1B27FC3, 0, 1, 1, 0);
    finish_pkt(1);

    // Byte arriving on the last allowed idle cycle still wins
    send_byte(8'h5A, 0);
    send_byte(8'hA5, TO - 1);
    send_byte(8'h80, TO - 1);
    send_byte(8'h3C, TO - 1);
    issue_verdict(32'h5AA5803C, 0, 1, 1, 0);
    finish_pkt(1);

    // Timeout discards a partial packet
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    repeat (TO - 1) cyc();
    @(negedge clk);
    chk("to_busy_pre", busy, 1);
    chk("to_eto_pre", err_timeout, 0);
    cyc();
    @(negedge clk);
    chk("to_busy", busy, 0);
    chk("to_eto", err_timeout, 1);
    to_exp = 1;
    cyc();
    do_pkt(32'h01020003, 0, 0, 2, 1, 0);

    // Backpressure on both sides
    ordy_mode = 2;
    do_pkt(32'h9C41FF07, 3, 5, 1, 1, 0);

    // Overrun during the verdict wait
    ordy_mode = 0;
    do_pkt(32'hDEAD80EF, 2, 0, 3, 1, 1);

    // Randomized mix
    ordy_mode = 1;
    repeat (60) begin
      if ($urandom % 8 == 0) begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++)
          send_byte(8'($urandom), $urandom_range(0, TO - 1));
        repeat (TO) cyc();
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_eto", err_timeout, 1);
        to_exp = 1;
        cyc();
      end else begin
        do_pkt($urandom, $urandom_range(0, TO - 1), $urandom_range(0, 4),
               $urandom_range(1, 4), 1'($urandom % 2),
               ($urandom % 5 == 0));
      end
    end

    // Reject counter saturation
    ordy_mode = 0;
    repeat (300) do_pkt(32'h12348056, 0, 0, 1, 0, 0);
    chk("drop_sat", drop_cnt, 255);

    // Async reset mid-emit
    send_pkt(32'hCAFE80BE, 0);
    issue_verdict(32'hCAFE80BE, 0, 1, 1, 0);
    for (int k = 0; k < 50 && got.size() < 2; k++) begin
      @(negedge clk);
      #1;
    end
    chk("pre_rst_n", got.size(), 2);
    #1 rst_n = 1'b0;
    #1;
    chk_zero("arst");
    got.delete();
    expq.delete();
    drop_exp = 0;
    to_exp   = 0;
    ov_exp   = 0;
    cyc();
    rst_n = 1'b1;
    cyc();
    do_pkt(32'h0BADF00D, 1, 0, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/event_filter_seq.md
Name: event_filter_seq

Overview:
Sequencer that sits between the 8-bit pin interface and the event filter datapath. It assembles 4-byte address-event packets (x, y, polarity, timestamp) from a byte stream and issues them to the filter with a valid/ready handshake. It collects the filter verdict, then serializes passed events back out one byte at a time. Rejected events are counted and never emitted.

Parameters:
TIMEOUT, 255, max idle cycles between bytes of one packet before the partial packet is discarded (1..65535)
DROP_W, 8, width of saturating reject counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  design enable; low freezes all state (no transitions, counters hold)
in_byte  in  8  incoming packet byte
in_valid  in  1  single-cycle strobe, in_byte valid this cycle (already synchronized)
f_x  out  8  event x to filter
f_y  out  8  event y to filter
f_p  out  1  event polarity to filter
f_t  out  8  event timestamp to filter
f_valid  out  1  event presented to filter
f_ready  in  1  filter accepts event
r_valid  in  1  filter verdict valid (single cycle)
r_pass  in  1  verdict: 1 = keep, 0 = reject
out_byte  out  8  serialized output byte
out_valid  out  1  out_byte valid
out_ready  in  1  sink accepts out_byte
busy  out  1  high in any state except IDLE
drop_cnt  out  DROP_W  saturating count of rejected events
err_timeout  out  1  sticky: partial packet discarded by timeout
err_overrun  out  1  sticky: in_valid seen while not accepting

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0: f_*, f_valid, out_byte, out_valid, busy, drop_cnt, err_timeout, err_overrun. Byte index and timeout counter 0. Reset mid-packet or mid-emit discards everything.
- Byte order in and out: 0=x, 1=y, 2=flags (bit7=p; bits6:0 ignored on input, driven 0 on output), 3=t.
- All actions below require ena=1. Sticky flags clear only on reset.
- IDLE: in_valid latches byte 0 → COLLECT, idx=1, timer=0.
- COLLECT: in_valid latches byte[idx], idx++, timer=0. Without in_valid, timer++. When timer reaches TIMEOUT → IDLE, err_timeout=1, partial packet discarded. Accepting byte 3 → ISSUE next cycle.
- ISSUE: f_valid=1; f_x/f_y/f_p/f_t held stable. f_valid rises the cycle after byte 3 is accepted. Transfer happens on f_valid&f_ready → WAIT_RES, f_valid=0 next cycle.
- WAIT_RES: on r_valid&r_pass → EMIT, out idx=0. On r_valid&!r_pass → drop_cnt++ (saturating at all-ones) → IDLE. r_valid in any other state is ignored.
- EMIT: out_valid=1, out_byte=byte[out idx], registered. On out_valid&out_ready, idx advances; after byte 3 transfers → IDLE with out_valid=0. out_byte is stable while out_ready=0.
- in_valid in ISSUE, WAIT_RES or EMIT: byte ignored, err_overrun=1, state unaffected.
- An in_valid in the same cycle as the IDLE transition is ignored and not flagged. The first byte is accepted one cycle after returning to IDLE.
- Timeout and in_valid in the same cycle: the byte wins, timer resets, no error.
- Minimum packet turnaround with ready sinks is 4 collect + 1 issue + verdict latency + 4 emit cycles.

Test Plan:
- Pass path: bytes 0x12,0x34,0x80,0x56 back-to-back, f_ready=1, verdict pass 2 cycles later, out_ready=1 → f_x=0x12 f_y=0x34 f_p=1 f_t=0x56. f_valid is high exactly 1 cycle, starting the cycle after byte 3. out_byte sequence is 0x12,0x34,0x80,0x56, then busy=0.
- Reject path: same packet with r_pass=0, repeated 300 times with DROP_W=8 → no out_valid ever; drop_cnt=255 (saturated).
- Timeout: TIMEOUT=10; send 2 bytes, then silence 10 cycles → state IDLE, err_timeout=1. A following full packet 0x01,0x02,0x00,0x03 is processed correctly.
- Backpressure: f_ready=0 for 5 cycles, then out_ready toggling 1/0 → f_* stable while waiting. Each out_byte is held until accepted; no byte duplicated or skipped.
- Overrun: in_valid pulsed during WAIT_RES → err_overrun=1, emitted packet unchanged.
- Async reset during EMIT after byte 1 → all outputs 0 immediately. The next packet emits from byte 0.
